// File: rtl/core_issue_pkg.sv
// Shared types and constants for the in-order issue controller: instruction
// class encodings, FSM state encoding and scoreboard indexing helpers.
package core_issue_pkg;

    localparam int NUM_REGS = 32;
    localparam int SB_IDX_W = 6;
    localparam int SB_SIZE  = 2 * NUM_REGS;

    typedef enum logic [2:0] {
        CLS_ALU        = 3'd0,
        CLS_LOAD       = 3'd1,
        CLS_STORE      = 3'd2,
        CLS_BRANCH     = 3'd3,
        CLS_FPU_MULTI  = 3'd4,
        CLS_FPU_SINGLE = 3'd5,
        CLS_IO         = 3'd6
    } dec_class_e;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_WAIT_BR = 1'b1
    } issue_state_e;

    // Scoreboard bit for a register: FP file occupies the upper half.
    function automatic logic [SB_IDX_W-1:0] sb_idx(input logic fp, input logic [4:0] r);
        return {fp, r};
    endfunction

    function automatic logic uses_rs2(input logic [2:0] cls);
        return (cls == CLS_STORE) || (cls == CLS_BRANCH) ||
               (cls == CLS_FPU_MULTI) || (cls == CLS_FPU_SINGLE);
    endfunction

    function automatic logic uses_mem(input logic [2:0] cls);
        return (cls == CLS_LOAD) || (cls == CLS_STORE) || (cls == CLS_IO);
    endfunction

endpackage

// File: rtl/core_scoreboard.sv
// 64-entry pending-write scoreboard (32 integer + 32 FP registers) with one
// set port, one clear port and three read ports. Set wins over clear.
module core_scoreboard
    import core_issue_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       i_set_en,
    input  logic       i_set_fp,
    input  logic [4:0] i_set_rd,
    input  logic       i_clr_en,
    input  logic       i_clr_fp,
    input  logic [4:0] i_clr_rd,
    input  logic       i_rs1_fp,
    input  logic [4:0] i_rs1,
    input  logic       i_rs2_fp,
    input  logic [4:0] i_rs2,
    input  logic       i_rd_fp,
    input  logic [4:0] i_rd,
    output logic       o_rs1_pend,
    output logic       o_rs2_pend,
    output logic       o_rd_pend
);

    logic [SB_SIZE-1:0] r_pend;
    logic [SB_SIZE-1:0] w_set_mask;
    logic [SB_SIZE-1:0] w_clr_mask;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        w_set_mask = '0;
        w_clr_mask = '0;
        // Integer x0 is never marked, so its bit always reads clear.
        if (i_set_en && (i_set_fp || (i_set_rd != 5'd0)))
            w_set_mask[sb_idx(i_set_fp, i_set_rd)] = 1'b1;
        if (i_clr_en)
            w_clr_mask[sb_idx(i_clr_fp, i_clr_rd)] = 1'b1;
    end

    // NOTE: the pending vector must be reset; stale bits after reset would block issue forever.
    always_ff @(posedge CLK) begin
        if (!RST_N)
            r_pend <= '0;
        else
            // NOTE: sequential state uses non-blocking assignment only.
            r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
    end

    assign o_rs1_pend = r_pend[sb_idx(i_rs1_fp, i_rs1)];
    assign o_rs2_pend = r_pend[sb_idx(i_rs2_fp, i_rs2)];
    assign o_rd_pend  = r_pend[sb_idx(i_rd_fp,  i_rd)];

endmodule

// File: rtl/core_issue_ctrl.sv
// In-order issue controller: hazard checks against the scoreboard, FPU busy
// tracking, branch-resolution hold with registered flush, stall counter.
module core_issue_ctrl
    import core_issue_pkg::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        DEC_VALID,
    output logic        DEC_READY,
    input  logic [2:0]  DEC_CLASS,
    input  logic [4:0]  DEC_RD,
    input  logic [4:0]  DEC_RS1,
    input  logic [4:0]  DEC_RS2,
    input  logic        DEC_RD_FP,
    input  logic        DEC_RS1_FP,
    input  logic        DEC_RS2_FP,
    input  logic        DEC_WRITES_RD,
    input  logic        MEM_READY,
    input  logic        FPU_DONE,
    input  logic        BR_RESOLVED,
    input  logic        BR_TAKEN,
    input  logic        WB_VALID,
    input  logic [4:0]  WB_RD,
    input  logic        WB_FP,
    output logic        FLUSH,
    output logic [31:0] STALL_CNT
);

    issue_state_e r_state;
    issue_state_e w_next_state;
    logic         r_fpu_busy;
    logic         r_flush;
    logic [31:0]  r_stall_cnt;
    logic         w_rs1_pend;
    logic         w_rs2_pend;
    logic         w_rd_pend;
    logic         w_raw;
    logic         w_waw;
    logic         w_struct;
    logic         w_issue;

    core_scoreboard u_scoreboard (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .i_set_en   (w_issue & DEC_WRITES_RD),
        .i_set_fp   (DEC_RD_FP),
        .i_set_rd   (DEC_RD),
        .i_clr_en   (WB_VALID),
        .i_clr_fp   (WB_FP),
        .i_clr_rd   (WB_RD),
        .i_rs1_fp   (DEC_RS1_FP),
        .i_rs1      (DEC_RS1),
        .i_rs2_fp   (DEC_RS2_FP),
        .i_rs2      (DEC_RS2),
        .i_rd_fp    (DEC_RD_FP),
        .i_rd       (DEC_RD),
        .o_rs1_pend (w_rs1_pend),
        .o_rs2_pend (w_rs2_pend),
        .o_rd_pend  (w_rd_pend)
    );

    assign w_raw    = w_rs1_pend | (uses_rs2(DEC_CLASS) & w_rs2_pend);
    assign w_waw    = DEC_WRITES_RD & w_rd_pend;
    assign w_struct = (uses_mem(DEC_CLASS) & ~MEM_READY) |
                      ((DEC_CLASS == CLS_FPU_MULTI) & r_fpu_busy);

    always_ff @(posedge CLK) begin
        if (!RST_N)
            r_state <= ST_RUN;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RUN:     if (w_issue && (DEC_CLASS == CLS_BRANCH)) w_next_state = ST_WAIT_BR;
            ST_WAIT_BR: if (BR_RESOLVED) w_next_state = ST_RUN;
            default:    w_next_state = ST_RUN;
        endcase
    end

    // Issue is blocked in reset, outside RUN and during the flush cycle.
    always_comb begin
        w_issue = 1'b0;
        if (RST_N && (r_state == ST_RUN) && !r_flush)
            w_issue = DEC_VALID & ~w_raw & ~w_waw & ~w_struct;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_fpu_busy  <= 1'b0;
            r_flush     <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            // A new FPU_MULTI issue outranks a simultaneous completion.
            r_fpu_busy <= (w_issue && (DEC_CLASS == CLS_FPU_MULTI)) || (r_fpu_busy && !FPU_DONE);
            r_flush    <= (r_state == ST_WAIT_BR) && BR_RESOLVED && BR_TAKEN;
            if (DEC_VALID && !w_issue)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign DEC_READY = w_issue;
    assign FLUSH     = r_flush;
    assign STALL_CNT = r_stall_cnt;

endmodule

// File: tb/tb_core_issue_ctrl.sv
// Directed testbench for core_issue_ctrl: one task per scenario, inputs driven
// 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_core_issue_ctrl;
    import core_issue_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        DEC_VALID;
    logic        DEC_READY;
    logic [2:0]  DEC_CLASS;
    logic [4:0]  DEC_RD, DEC_RS1, DEC_RS2;
    logic        DEC_RD_FP, DEC_RS1_FP, DEC_RS2_FP;
    logic        DEC_WRITES_RD;
    logic        MEM_READY;
    logic        FPU_DONE;
    logic        BR_RESOLVED;
    logic        BR_TAKEN;
    logic        WB_VALID;
    logic [4:0]  WB_RD;
    logic        WB_FP;
    logic        FLUSH;
    logic [31:0] STALL_CNT;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    core_issue_ctrl dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .DEC_VALID     (DEC_VALID),
        .DEC_READY     (DEC_READY),
        .DEC_CLASS     (DEC_CLASS),
        .DEC_RD        (DEC_RD),
        .DEC_RS1       (DEC_RS1),
        .DEC_RS2       (DEC_RS2),
        .DEC_RD_FP     (DEC_RD_FP),
        .DEC_RS1_FP    (DEC_RS1_FP),
        .DEC_RS2_FP    (DEC_RS2_FP),
        .DEC_WRITES_RD (DEC_WRITES_RD),
        .MEM_READY     (MEM_READY),
        .FPU_DONE      (FPU_DONE),
        .BR_RESOLVED   (BR_RESOLVED),
        .BR_TAKEN      (BR_TAKEN),
        .WB_VALID      (WB_VALID),
        .WB_RD         (WB_RD),
        .WB_FP         (WB_FP),
        .FLUSH         (FLUSH),
        .STALL_CNT     (STALL_CNT)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        DEC_VALID     = 1'b0;
        DEC_CLASS     = CLS_ALU;
        DEC_RD        = 5'd0;
        DEC_RS1       = 5'd0;
        DEC_RS2       = 5'd0;
        DEC_RD_FP     = 1'b0;
        DEC_RS1_FP    = 1'b0;
        DEC_RS2_FP    = 1'b0;
        DEC_WRITES_RD = 1'b0;
        MEM_READY     = 1'b1;
        FPU_DONE      = 1'b0;
        BR_RESOLVED   = 1'b0;
        BR_TAKEN      = 1'b0;
        WB_VALID      = 1'b0;
        WB_RD         = 5'd0;
        WB_FP         = 1'b0;
    endtask

    task automatic dec(input logic [2:0] cls, input logic [4:0] rd, input logic rd_fp,
                       input logic wr, input logic [4:0] rs1, input logic rs1_fp,
                       input logic [4:0] rs2, input logic rs2_fp);
        DEC_VALID     = 1'b1;
        DEC_CLASS     = cls;
        DEC_RD        = rd;
        DEC_RD_FP     = rd_fp;
        DEC_WRITES_RD = wr;
        DEC_RS1       = rs1;
        DEC_RS1_FP    = rs1_fp;
        DEC_RS2       = rs2;
        DEC_RS2_FP    = rs2_fp;
    endtask

    task automatic apply_reset();
        idle();
        RST_N = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        RST_N = 1'b0;
        dec(CLS_ALU, 5'd1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        tick();
        @(negedge CLK);
        n_cmp++;
        if (DEC_READY !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got %b want 0", DEC_READY);
        end
        n_cmp++;
        if (FLUSH !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flush: got %b want 0", FLUSH);
        end
        n_cmp++;
        if (STALL_CNT !== 32'd0) begin
            n_err++;
            $display("FAIL reset_stall_cnt: got %0d want 0", STALL_CNT);
        end
        tick();
        RST_N = 1'b1;
        idle();
    endtask

    // Producer x5 then consumer on rs1=x5; WB of x5 in consumer cycle 3.
    task automatic test_raw();
        apply_reset();
        dec(CLS_ALU, 5'd5, 1'b0, 1'b1, 5'd1, 1'b0, 5'd2, 1'b0);
        @(negedge CLK);
        n_cmp++;
        if (DEC_READY !== 1'b1) begin
            n_err++;
            $display("FAIL raw_producer: got %b want 1", DEC_READY);
        end
        tick();
        for (int c = 1; c <= 4; c++) begin
            dec(CLS_ALU, 5'd8, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0);
            WB_VALID = (c == 3);
            WB_RD    = 5'd5;
            WB_FP    = 1'b0;
            @(negedge CLK);
            n_cmp++;
            if (DEC_READY !== (c == 4)) begin
                n_err++;
                $display("FAIL raw_consumer_c%0d: got %b want %b", c, DEC_READY, (c == 4));
            end
            if (c == 4) begin
                n_cmp++;
                if (STALL_CNT !== 32'd3) begin
                    n_err++;
                    $display("FAIL raw_stall_cnt: got %0d want 3", STALL_CNT);
                end
            end
            tick();
        end
        idle();
    endtask

    // x0 never pending, WAW, file separation, ALU ignores RS2, STORE uses RS2, set-wins.
    task automatic test_x0_waw();
        logic [2:0] cls    [7];
        logic [4:0] rd     [7];
        logic       rd_fp  [7];
        logic       wr     [7];
        logic [4:0] rs1    [7];
        logic       rs1_fp [7];
        logic [4:0] rs2    [7];
        logic       wb_en  [7];
        logic       exp_rdy[7];
        cls = '{CLS_ALU, CLS_STORE, CLS_ALU, CLS_ALU, CLS_FPU_SINGLE, CLS_ALU, CLS_STORE};
        rd  = '{5'd0, 5'd0, 5'd6, 5'd6, 5'd6, 5'd10, 5'd0};
        rd_fp  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        wr     = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        rs1    = '{5'd0, 5'd0, 5'd1, 5'd0, 5'd6, 5'd0, 5'd0};
        rs1_fp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        rs2    = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd6, 5'd6, 5'd6};
        wb_en  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            dec(cls[i], rd[i], rd_fp[i], wr[i], rs1[i], rs1_fp[i], rs2[i], rs1_fp[i]);
            WB_VALID = wb_en[i];
            @(negedge CLK);
            n_cmp++;
            if (DEC_READY !== exp_rdy[i]) begin
                n_err++;
                $display("FAIL x0_waw_step%0d: got %b want %b", i, DEC_READY, exp_rdy[i]);
            end
            tick();
        end
        dec(CLS_ALU, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        WB_VALID = 1'b1;
        WB_RD    = 5'd7;
        WB_FP    = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (DEC_READY !== 1'b1) begin
            n_err++;
            $display("FAIL setwins_issue: got %b want 1", DEC_READY);
        end
        tick();
        WB_VALID = 1'b0;
        dec(CLS_ALU, 5'd9, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0);
        @(negedge CLK);
        n_cmp++;
        if (DEC_READY !== 1'b0) begin
            n_err++;
            $display("FAIL setwins_consumer: got %b want 0", DEC_READY);
        end
        tick();
        idle();
        @(negedge CLK);
        n_cmp++;
        if (STALL_CNT !== 32'd3) begin
            n_err++;
            $display("FAIL x0_waw_stall_cnt: got %0d want 3", STALL_CNT);
        end
        tick();
    endtask

    task automatic test_fpu();
        logic [2:0] cls    [6];
        logic [4:0] rd     [6];
        logic       done   [6];
        logic       exp_rdy[6];
        cls  = '{CLS_FPU_MULTI, CLS_FPU_MULTI, CLS_FPU_MULTI, CLS_FPU_MULTI, CLS_FPU_MULTI, CLS_FPU_SINGLE};
        rd   = '{5'd2, 5'd3, 5'd3, 5'd3, 5'd4, 5'd5};
        done = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            dec(cls[i], rd[i], 1'b1, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1);
            FPU_DONE = done[i];
            @(negedge CLK);
            n_cmp++;
            if (DEC_READY !== exp_rdy[i]) begin
                n_err++;
                $display("FAIL fpu_step%0d: got %b want %b", i, DEC_READY, exp_rdy[i]);
            end
            if (i == 5) begin
                n_cmp++;
                if (STALL_CNT !== 32'd3) begin
                    n_err++;
                    $display("FAIL fpu_stall_cnt: got %0d want 3", STALL_CNT);
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_mem();
        logic [2:0] cls    [4];
        logic       mrdy   [4];
        logic       exp_rdy[4];
        cls  = '{CLS_LOAD, CLS_LOAD, CLS_LOAD, CLS_IO};
        mrdy = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_rdy = '{1'b0, 1'b0, 1'b1, 1'b0};
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            dec(cls[i], 5'd12, 1'b0, 1'b1, 5'd1, 1'b0, 5'd2, 1'b0);
            if (i == 3) DEC_WRITES_RD = 1'b0;
            MEM_READY = mrdy[i];
            @(negedge CLK);
            n_cmp++;
            if (DEC_READY !== exp_rdy[i]) begin
                n_err++;
                $display("FAIL mem_step%0d: got %b want %b", i, DEC_READY, exp_rdy[i]);
            end
            tick();
        end
        idle();
        @(negedge CLK);
        n_cmp++;
        if (STALL_CNT !== 32'd3) begin
            n_err++;
            $display("FAIL mem_stall_cnt: got %0d want 3", STALL_CNT);
        end
        tick();
    endtask

    task automatic test_branch();
        logic [2:0] cls      [9];
        logic       res      [9];
        logic       tkn      [9];
        logic       exp_rdy  [9];
        logic       exp_flush[9];
        cls = '{CLS_BRANCH, CLS_ALU, CLS_ALU, CLS_ALU, CLS_ALU, CLS_ALU, CLS_BRANCH, CLS_ALU, CLS_ALU};
        res = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        tkn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_rdy   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_flush = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        apply_reset();
        for (int i = 0; i < 9; i++) begin
            dec(cls[i], 5'd0, 1'b0, 1'b0, 5'd1, 1'b0, 5'd2, 1'b0);
            BR_RESOLVED = res[i];
            BR_TAKEN    = tkn[i];
            @(negedge CLK);
            n_cmp++;
            if (DEC_READY !== exp_rdy[i]) begin
                n_err++;
                $display("FAIL branch_ready_c%0d: got %b want %b", i, DEC_READY, exp_rdy[i]);
            end
            n_cmp++;
            if (FLUSH !== exp_flush[i]) begin
                n_err++;
                $display("FAIL branch_flush_c%0d: got %b want %b", i, FLUSH, exp_flush[i]);
            end
            tick();
        end
        idle();
        @(negedge CLK);
        n_cmp++;
        if (FLUSH !== 1'b0) begin
            n_err++;
            $display("FAIL branch_flush_run_resolve: got %b want 0", FLUSH);
        end
        n_cmp++;
        if (STALL_CNT !== 32'd6) begin
            n_err++;
            $display("FAIL branch_stall_cnt: got %0d want 6", STALL_CNT);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        dec(CLS_FPU_SINGLE, 5'd7, 1'b1, 1'b1, 5'd1, 1'b1, 5'd2, 1'b1);
        @(negedge CLK);
        n_cmp++;
        if (DEC_READY !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_producer: got %b want 1", DEC_READY);
        end
        tick();
        dec(CLS_FPU_SINGLE, 5'd9, 1'b1, 1'b1, 5'd7, 1'b1, 5'd2, 1'b1);
        @(negedge CLK);
        n_cmp++;
        if (DEC_READY !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_stall: got %b want 0", DEC_READY);
        end
        tick();
        @(negedge CLK);
        n_cmp++;
        if (STALL_CNT !== 32'd1) begin
            n_err++;
            $display("FAIL midrst_cnt_before: got %0d want 1", STALL_CNT);
        end
        tick();
        RST_N = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if (DEC_READY !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_ready_in_reset: got %b want 0", DEC_READY);
        end
        tick();
        RST_N    = 1'b1;
        WB_VALID = 1'b1;
        WB_RD    = 5'd7;
        WB_FP    = 1'b1;
        FPU_DONE = 1'b1;
        @(negedge CLK);
        n_cmp++;
        if (DEC_READY !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_f7_clear: got %b want 1", DEC_READY);
        end
        n_cmp++;
        if (STALL_CNT !== 32'd0) begin
            n_err++;
            $display("FAIL midrst_stall_cnt: got %0d want 0", STALL_CNT);
        end
        n_cmp++;
        if (FLUSH !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_flush: got %b want 0", FLUSH);
        end
        tick();
        idle();
    endtask

    initial begin
        RST_N = 1'b0;
        idle();
        test_reset();
        test_raw();
        test_x0_waw();
        test_fpu();
        test_mem();
        test_branch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
